// File: rtl/ula_ctrl_pkg.sv
// Shared encodings for the ULA control sequencer: opcodes, ALU op codes,
// FSM states and instruction field positions.
package ula_ctrl_pkg;

    localparam logic [3:0] OPC_ADD  = 4'h0;
    localparam logic [3:0] OPC_SUB  = 4'h1;
    localparam logic [3:0] OPC_NAND = 4'h2;
    localparam logic [3:0] OPC_MOV  = 4'h3;
    localparam logic [3:0] OPC_LDI  = 4'h4;
    localparam logic [3:0] OPC_BZ   = 4'h5;
    localparam logic [3:0] OPC_HLT  = 4'hF;

    // op_select codes, shared with the ALU
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_NAND = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;
    localparam int IMM_MSB = 7;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Branch offset lives in the rd and rt nibbles so rs stays free for the test register.
    function automatic logic [7:0] bz_offset(input logic [15:0] instr);
        return {instr[RD_MSB:RD_LSB], instr[RT_MSB:RT_LSB]};
    endfunction

endpackage

// File: rtl/ula_ctrl_dec.sv
// Combinational instruction decoder for the ULA control sequencer.
// Opcode 5 decodes as branch-on-zero only when ULA_CTRL_BZ_EN is defined.
module ula_ctrl_dec
    import ula_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [1:0]  op_select,
    output logic        we,
    output logic        imm_sel,
    output logic        is_branch,
    output logic        is_halt,
    output logic        illegal,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm,
    output logic [7:0]  offset
);

    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign imm    = {8'h00, instr[IMM_MSB:0]};
    assign offset = bz_offset(instr);

    always_comb begin
        op_select = ALU_PASS;
        we        = 1'b0;
        imm_sel   = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        illegal   = 1'b0;
        case (instr[OPC_MSB:OPC_LSB])
            OPC_ADD: begin
                op_select = ALU_ADD;
                we        = 1'b1;
            end
            OPC_SUB: begin
                op_select = ALU_SUB;
                we        = 1'b1;
            end
            OPC_NAND: begin
                op_select = ALU_NAND;
                we        = 1'b1;
            end
            OPC_MOV: begin
                op_select = ALU_PASS;
                we        = 1'b1;
            end
            OPC_LDI: begin
                we        = 1'b1;
                imm_sel   = 1'b1;
            end
`ifdef ULA_CTRL_BZ_EN
            OPC_BZ: begin
                is_branch = 1'b1;
            end
`endif
            OPC_HLT: begin
                is_halt   = 1'b1;
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ula_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the 16-bit ALU.
// Branch-on-zero (opcode 5) is built in only when ULA_CTRL_BZ_EN is defined.
//
// state     | meaning
// FETCH     | raise instr_req, wait for instr_ack, latch the instruction
// DECODE    | decoded fields on the outputs; HLT diverts to HALT
// EXEC      | ALU evaluates; alu_zero captured at the end of the cycle
// WB        | reg_we pulse, pc update, re-request next instruction
// HALT      | parked until reset
module ula_ctrl
    import ula_ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               instr_req,
    input  logic               instr_ack,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    pc,
    output logic [1:0]         op_select,
    output logic [3:0]         rs_addr,
    output logic [3:0]         rt_addr,
    output logic [3:0]         rd_addr,
    output logic [15:0]        imm,
    output logic               imm_sel,
    output logic               reg_we,
    input  logic               alu_zero,
    output logic               halt
);

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic                zero_q;
    logic [15:0]         dec_in;
    logic [1:0]          dec_op;
    logic                dec_we;
    logic                dec_imm_sel;
    logic                dec_branch;
    logic                dec_halt;
    logic                unused_illegal;
    logic [3:0]          dec_rd;
    logic [3:0]          dec_rs;
    logic [3:0]          dec_rt;
    logic [15:0]         dec_imm;
    logic [7:0]          dec_offset;
    logic signed [31:0]  off_sext;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     pc_tgt;

    // One decoder: it sees the incoming word during FETCH so the fields can be
    // registered on the ack edge, and the latched word in every later state.
    assign dec_in = (state == ST_FETCH) ? 16'(instr_data) : 16'(ir);

    ula_ctrl_dec u_dec (
        .instr     (dec_in),
        .op_select (dec_op),
        .we        (dec_we),
        .imm_sel   (dec_imm_sel),
        .is_branch (dec_branch),
        .is_halt   (dec_halt),
        .illegal   (unused_illegal),
        .rd        (dec_rd),
        .rs        (dec_rs),
        .rt        (dec_rt),
        .imm       (dec_imm),
        .offset    (dec_offset)
    );

    assign off_sext = 32'(signed'(dec_offset));
    assign pc_inc   = pc + PC_W'(1);
    assign pc_tgt   = PC_W'(32'(pc) + off_sext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= '0;
            ir        <= '0;
            zero_q    <= 1'b0;
            instr_req <= 1'b0;
            reg_we    <= 1'b0;
            imm_sel   <= 1'b0;
            op_select <= ALU_PASS;
            rs_addr   <= '0;
            rt_addr   <= '0;
            rd_addr   <= '0;
            imm       <= '0;
            halt      <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            imm_sel <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (!instr_req) begin
                        instr_req <= 1'b1;
                    end else if (instr_ack) begin
                        instr_req <= 1'b0;
                        ir        <= instr_data;
                        op_select <= dec_op;
                        rd_addr   <= dec_rd;
                        rs_addr   <= dec_rs;
                        rt_addr   <= dec_rt;
                        imm       <= dec_imm;
                        state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_halt) begin
                        halt  <= 1'b1;
                        state <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    zero_q  <= alu_zero;
                    reg_we  <= dec_we;
                    imm_sel <= dec_imm_sel;
                    state   <= ST_WB;
                end
                ST_WB: begin
                    pc        <= (dec_branch && zero_q) ? pc_tgt : pc_inc;
                    instr_req <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_ctrl.sv
// Scoreboard bench for ula_ctrl: directed instructions push expected writebacks
// and pc updates; a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_ula_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_req;
    logic        instr_ack = 1'b0;
    logic [15:0] instr_data = 16'h0000;
    logic [7:0]  pc;
    logic [1:0]  op_select;
    logic [3:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm;
    logic        imm_sel, reg_we, halt;
    logic        alu_zero = 1'b0;

    ula_ctrl #(.PC_W(8), .INSTR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .pc         (pc),
        .op_select  (op_select),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .reg_we     (reg_we),
        .alu_zero   (alu_zero),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rd, rs, rt;
        logic [15:0] imm;
        logic        sel;
        int          cyc;
    } we_exp_t;

    we_exp_t     we_q[$];
    logic [7:0]  pc_q[$];
    logic [7:0]  mpc = 8'h00;
    logic [7:0]  pc_prev = 8'h00;
    logic        mon_en = 1'b0;
    we_exp_t     mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every write strobe and every pc change.
    always @(negedge clk) begin
        if (!rst_n) begin
            pc_prev = pc;
        end else if (mon_en) begin
            if (reg_we) begin
                if (we_q.size() == 0) begin
                    chk("unexpected_reg_we", 32'(reg_we), 32'd0);
                end else begin
                    mon_e = we_q.pop_front();
                    chk("wb_fields", {17'd0, op_select, rd_addr, rs_addr, rt_addr, imm_sel},
                        {17'd0, mon_e.op, mon_e.rd, mon_e.rs, mon_e.rt, mon_e.sel});
                    chk("wb_imm", 32'(imm), 32'(mon_e.imm));
                    chk("wb_cycle", cyc, mon_e.cyc);
                end
            end
            if (pc !== pc_prev) begin
                if (pc_q.size() == 0) chk("unexpected_pc_change", 32'(pc), 32'(pc_prev));
                else                  chk("pc_update", 32'(pc), 32'(pc_q.pop_front()));
                pc_prev = pc;
            end
        end
    end

    // Memory side: wait for a request, hold off ack for dly cycles, ack for one cycle.
    task automatic serve(input logic [15:0] w, input int dly, output int acyc, output int req_cnt);
        int n = 0;
        while (instr_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(instr_req), 32'd1);
        req_cnt = 1;
        repeat (dly) begin
            @(negedge clk);
            if (instr_req === 1'b1) req_cnt++;
        end
        acyc       = cyc;
        instr_ack  = 1'b1;
        instr_data = w;
        @(negedge clk);
        instr_ack  = 1'b0;
        instr_data = 16'hFFFF;
    endtask

    task automatic issue_we(input logic [15:0] w, input int dly, input logic [1:0] op,
                            input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [15:0] im, input logic sel, output int req_cnt);
        int a;
        we_exp_t e;
        mpc = mpc + 8'd1;
        pc_q.push_back(mpc);
        serve(w, dly, a, req_cnt);
        e.op = op; e.rd = rd; e.rs = rs; e.rt = rt; e.imm = im; e.sel = sel;
        e.cyc = a + 3;
        we_q.push_back(e);
    endtask

    task automatic issue_nowe(input logic [15:0] w, input int dly, input logic [7:0] exp_pc);
        int a, r;
        mpc = exp_pc;
        pc_q.push_back(exp_pc);
        serve(w, dly, a, r);
    endtask

    task automatic nop();
        issue_nowe(16'h6000, 0, 8'(mpc + 8'd1));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((we_q.size() + pc_q.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, we_q.size() + pc_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},      32'(pc), 32'h0);
        chk({tag, "_req"},     32'(instr_req), 32'd0);
        chk({tag, "_reg_we"},  32'(reg_we), 32'd0);
        chk({tag, "_op"},      32'(op_select), 32'd3);
        chk({tag, "_halt"},    32'(halt), 32'd0);
        chk({tag, "_addrs"},   {20'd0, rd_addr, rs_addr, rt_addr}, 32'h0);
        chk({tag, "_imm"},     {15'd0, imm, imm_sel}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, n, bad_req, bad_pc, bad_halt;

        // Reset: 3 cycles low, values checked while held and right after release.
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_values("rst_hold");
        #1 rst_n = 1'b1;
        #1 chk("req_low_at_release", 32'(instr_req), 32'd0);
        mon_en = 1'b1;
        mpc = 8'h00;
        @(negedge clk);
        chk("req_after_release", 32'(instr_req), 32'd1);

        issue_we(16'h0123, 0, 2'd0, 4'h1, 4'h2, 4'h3, 16'h0023, 1'b0, rc);
        issue_we(16'h45A7, 3, 2'd3, 4'h5, 4'hA, 4'h7, 16'h00A7, 1'b1, rc);
        chk("ldi_req_held_cycles", rc, 4);
        issue_we(16'h1456, 1, 2'd1, 4'h4, 4'h5, 4'h6, 16'h0056, 1'b0, rc);
        // ack raised while no request is outstanding must be ignored
        instr_ack = 1'b1; instr_data = 16'hF000;
        @(negedge clk); @(negedge clk);
        instr_ack = 1'b0; instr_data = 16'hFFFF;
        issue_we(16'h2789, 0, 2'd2, 4'h7, 4'h8, 4'h9, 16'h0089, 1'b0, rc);
        issue_nowe(16'h7123, 2, 8'(mpc + 8'd1));
        chk("illegal_op_select", 32'(op_select), 32'd3);
        issue_we(16'h3AB0, 0, 2'd3, 4'hA, 4'hB, 4'h0, 16'h00B0, 1'b0, rc);

        while (mpc != 8'd10) nop();
        drain("drain_before_bz");
        alu_zero = 1'b1;
`ifdef ULA_CTRL_BZ_EN
        issue_nowe(16'h5F2E, 0, 8'd8);
`else
        issue_nowe(16'h5F2E, 0, 8'd11);
`endif
        drain("drain_bz_taken");
        alu_zero = 1'b0;
        while (mpc < 8'd10) nop();
`ifdef ULA_CTRL_BZ_EN
        issue_nowe(16'h5F2E, 1, 8'd11);
`else
        issue_nowe(16'h5F2E, 1, 8'd12);
`endif
        drain("drain_bz_not_taken");

        // Illegal then HLT.
        issue_nowe(16'h7000, 0, 8'(mpc + 8'd1));
        serve(16'hF000, 0, n, rc);
        @(negedge clk);
        chk("halt_set", 32'(halt), 32'd1);
        bad_req = 0; bad_pc = 0; bad_halt = 0;
        repeat (20) begin
            @(negedge clk);
            if (instr_req !== 1'b0) bad_req++;
            if (pc !== mpc)         bad_pc++;
            if (halt !== 1'b1)      bad_halt++;
        end
        chk("halt_req_high_cycles", bad_req, 0);
        chk("halt_pc_moved_cycles", bad_pc, 0);
        chk("halt_dropped_cycles", bad_halt, 0);
        drain("drain_halt");

        // Reset out of HALT, then reset again while a request is pending.
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        mpc = 8'h00;
        n = 0;
        while (instr_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("req_after_halt_reset", 32'(instr_req), 32'd1);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_pending_req");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Walk to pc=0xFF, start an ADD, reset during EXEC.
        repeat (255) nop();
        drain("drain_to_ff");
        chk("pc_at_ff", 32'(pc), 32'hFF);
        serve(16'h0123, 0, n, rc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid_exec");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        mpc = 8'h00;
        repeat (6) @(negedge clk);

        // Walk to pc=0xFF again and let an ADD complete: pc wraps to 0.
        repeat (255) nop();
        issue_we(16'h0123, 0, 2'd0, 4'h1, 4'h2, 4'h3, 16'h0023, 1'b0, rc);
        drain("drain_wrap");
        chk("pc_wrapped", 32'(pc), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
